// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the segmented pipelined adder: stage count and parameter legality.
package pipe_adder_pkg;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic bit seg_cfg_ok(input int width, input int seg_w);
    return (seg_w >= 1) && (seg_w <= width) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One registered SEG_W-bit slice of the ripple chain: segment sum, carry-out and valid bit.
module adder_seg_stage #(
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             valid_in,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             carry_in,
  output logic             valid,
  output logic [SEG_W-1:0] seg_sum,
  output logic             carry_out
);

  typedef struct packed {
    logic             valid;
    logic [SEG_W-1:0] seg_sum;
    logic             carry;
  } stage_rec_t;

  logic [SEG_W:0] total;
  stage_rec_t     rec_d;
  stage_rec_t     rec_q;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, carry_in};

  always_comb begin
    rec_d         = '0;
    rec_d.valid   = valid_in;
    rec_d.seg_sum = total[SEG_W-1:0];
    rec_d.carry   = total[SEG_W];
  end

  // Bubble stages still load data; only the valid bit marks real results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
    end else if (adv) begin
      rec_q <= rec_d;
    end
  end

  assign valid     = rec_q.valid;
  assign seg_sum   = rec_q.seg_sum;
  assign carry_out = rec_q.carry;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one SEG_W-bit segment per stage, valid/ready on both sides.
// Optional subtract mode with signed overflow flag when PIPE_ADDER_SUB_EN is defined.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSEG   = nseg(WIDTH, SEG_W);
  localparam bit CFG_OK = seg_cfg_ok(WIDTH, SEG_W);

  if (!CFG_OK) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Handshake: input moves on in_valid && in_ready, output on out_valid && out_ready;
  // the whole pipe advances together whenever the output slot is empty or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef PIPE_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c0    = cin;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_st
    logic [SEG_W-1:0] sa;
    logic [SEG_W-1:0] sb;
    logic [SEG_W-1:0] seg;
    logic             ci;
    logic             vi;
    logic             co;
    logic             vo;

    if (k == 0) begin : g_head
      assign sa = a[SEG_W-1:0];
      assign sb = b_eff[SEG_W-1:0];
      assign ci = c0;
      assign vi = in_valid;
    end else begin : g_body
      assign sa = g_st[k-1].g_skew.ua[SEG_W-1:0];
      assign sb = g_st[k-1].g_skew.ub[SEG_W-1:0];
      assign ci = g_st[k-1].co;
      assign vi = g_st[k-1].vo;
    end

    adder_seg_stage #(.SEG_W(SEG_W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .valid_in  (vi),
      .a         (sa),
      .b         (sb),
      .carry_in  (ci),
      .valid     (vo),
      .seg_sum   (seg),
      .carry_out (co)
    );

    // Operand bits not yet consumed ride along until their segment's stage.
    if (k < NSEG - 1) begin : g_skew
      localparam int UW = WIDTH - (k + 1) * SEG_W;
      logic [UW-1:0] ua;
      logic [UW-1:0] ub;
      logic [UW-1:0] ua_nxt;
      logic [UW-1:0] ub_nxt;

      if (k == 0) begin : g_src
        assign ua_nxt = a[WIDTH-1:SEG_W];
        assign ub_nxt = b_eff[WIDTH-1:SEG_W];
      end else begin : g_src
        assign ua_nxt = g_st[k-1].g_skew.ua[UW+SEG_W-1:SEG_W];
        assign ub_nxt = g_st[k-1].g_skew.ub[UW+SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ua <= '0;
          ub <= '0;
        end else if (adv) begin
          ua <= ua_nxt;
          ub <= ub_nxt;
        end
      end
    end

    // Finished lower segments are carried forward so the full sum lines up at the end.
    if (k > 0) begin : g_lo
      logic [k*SEG_W-1:0] lo;
      logic [k*SEG_W-1:0] lo_nxt;

      if (k == 1) begin : g_src
        assign lo_nxt = g_st[0].seg;
      end else begin : g_src
        assign lo_nxt = {g_st[k-1].seg, g_st[k-1].g_lo.lo};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo <= '0;
        end else if (adv) begin
          lo <= lo_nxt;
        end
      end
    end
  end

  assign out_valid = g_st[NSEG-1].vo;
  assign cout      = g_st[NSEG-1].co;

  if (NSEG == 1) begin : g_sum_one
    assign sum = g_st[0].seg;
  end else begin : g_sum_many
    assign sum = {g_st[NSEG-1].seg, g_st[NSEG-1].g_lo.lo};
  end

`ifdef PIPE_ADDER_SUB_EN
  logic [SEG_W-1:0] msb_seg;
  logic             ovf_nxt;
  logic             ovf_q;

  // Signed overflow: operands agree in sign but the result's sign differs.
  assign msb_seg = g_st[NSEG-1].sa + g_st[NSEG-1].sb + SEG_W'(g_st[NSEG-1].ci);
  assign ovf_nxt = (g_st[NSEG-1].sa[SEG_W-1] == g_st[NSEG-1].sb[SEG_W-1]) &&
                   (msb_seg[SEG_W-1] != g_st[NSEG-1].sa[SEG_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder (WIDTH=16, SEG_W=4): directed steps plus randomized traffic
// against an arithmetic reference model and an expected-result queue.
module tb_pipe_adder;

  localparam int W    = 16;
  localparam int NSEG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPE_ADDER_SUB_EN
  logic         ovf;
`endif

  pipe_adder #(.WIDTH(W), .SEG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  bit lat_chk = 1'b0;

  // expected record: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  logic [W-1:0] src_a[$];
  logic [W-1:0] src_b[$];
  logic         src_c[$];
  logic         src_s[$];

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;
  bit           stalled = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  // reference model: integer arithmetic on the operands
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    int us, ss;
    logic co, ov;
    if (ms) begin
      us = int'(ma) - int'(mb);
      ss = int'($signed(ma)) - int'($signed(mb));
      co = (int'(ma) >= int'(mb));
    end else begin
      us = int'(ma) + int'(mb) + int'(mc);
      ss = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      co = (us > 65535);
    end
    ov = (ss > 32767) || (ss < -32768);
    return {ov, co, us[W-1:0]};
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [W+1:0] e;
    logic         s_eff;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
`ifdef PIPE_ADDER_SUB_EN
      s_eff = sub;
`else
      s_eff = 1'b0;
`endif
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, s_eff));
        acc_q.push_back(cyc);
      end
      n_tests++;
      assert (in_ready === (!out_valid || out_ready)) else begin
        n_fail++;
        $error("FAIL in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (stalled) begin
        n_tests++;
        assert (out_valid === 1'b1 && sum === held_sum && cout === held_cout) else begin
          n_fail++;
          $error("FAIL stall_hold: got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
                 out_valid, sum, cout, held_sum, held_cout);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_out: got sum=%h cout=%b want no result", sum, cout);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_tests++;
          assert (sum === e[W-1:0] && cout === e[W]) else begin
            n_fail++;
            $error("FAIL result: got sum=%h cout=%b want sum=%h cout=%b", sum, cout, e[W-1:0], e[W]);
          end
`ifdef PIPE_ADDER_SUB_EN
          n_tests++;
          assert (ovf === e[W+1]) else begin
            n_fail++;
            $error("FAIL ovf: got %b want %b", ovf, e[W+1]);
          end
          last_ovf = ovf;
`endif
          if (lat_chk) begin
            n_tests++;
            assert (cyc - acc_q[0] == NSEG) else begin
              n_fail++;
              $error("FAIL latency: got %0d want %0d", cyc - acc_q[0], NSEG);
            end
          end
          void'(acc_q.pop_front());
        end
        last_sum  = sum;
        last_cout = cout;
      end
      stalled   = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
    end
  end

  // driver tasks (entered and left just after a rising edge)
  task automatic add_pair(input logic [W-1:0] pa, input logic [W-1:0] pb,
                          input logic pc, input logic ps);
    src_a.push_back(pa);
    src_b.push_back(pb);
    src_c.push_back(pc);
    src_s.push_back(ps);
  endtask

  task automatic stream(input int stall_at, input int stall_len, input bit rnd, input int budget);
    int c;
    bit take;
    c = 0;
    while ((src_a.size() > 0 || exp_q.size() > 0) && c < budget) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (src_a.size() > 0 && !(rnd && $urandom_range(0, 4) == 0)) begin
        in_valid = 1'b1;
        a = src_a[0]; b = src_b[0]; cin = src_c[0]; sub = src_s[0];
      end else begin
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        void'(src_a.pop_front()); void'(src_b.pop_front());
        void'(src_c.pop_front()); void'(src_s.pop_front());
      end
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    assert (c < budget) else begin
      n_fail++;
      $error("FAIL timeout: got %0d cycles want < %0d", c, budget);
    end
  endtask

  task automatic check_last(input string tag, input logic [W-1:0] es, input logic ec);
    n_tests++;
    assert (last_sum === es && last_cout === ec) else begin
      n_fail++;
      $error("FAIL %s: got sum=%h cout=%b want sum=%h cout=%b", tag, last_sum, last_cout, es, ec);
    end
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    n_tests++;
    assert (got == want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    n_tests++;
    assert (in_ready === 1'b1 && out_valid === 1'b0 && sum === '0 && cout === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_idle: got rdy=%b v=%b sum=%h cout=%b want 1 0 0000 0",
             in_ready, out_valid, sum, cout);
    end
    @(posedge clk); #1;

    // single adds with latency check
    lat_chk = 1'b1;
    n0 = n_out;
    add_pair(16'h1234, 16'h4321, 1'b0, 1'b0);
    stream(0, 0, 1'b0, 50);
    check_count("single_count", n_out - n0, 1);
    check_last("single_add", 16'h5555, 1'b0);
    add_pair(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    stream(0, 0, 1'b0, 50);
    check_last("ripple_ffff_0_1", 16'h0000, 1'b1);
    add_pair(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    stream(0, 0, 1'b0, 50);
    check_last("ripple_ffff_ffff_1", 16'hFFFF, 1'b1);

    // back-to-back stream of 8
    n0 = n_out;
    for (int i = 0; i < 8; i++) add_pair(16'(i * 16'h1111), 16'h0F0F, 1'(i & 1), 1'b0);
    stream(0, 0, 1'b0, 100);
    check_count("stream8_count", n_out - n0, 8);
    lat_chk = 1'b0;

    // backpressure: consumer stalls 3 cycles mid-stream
    n0 = n_out;
    for (int i = 0; i < 6; i++) add_pair(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    stream(5, 3, 1'b0, 100);
    check_count("backpressure_count", n_out - n0, 6);
    check_count("backpressure_drain", exp_q.size(), 0);

    // reset mid-flight: three accepted, reset two cycles after the first
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b0;
    exp_q.delete(); acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      assert (out_valid === 1'b0) else begin
        n_fail++;
        $error("FAIL reset_flush: got out_valid=%b want 0 (cycle %0d)", out_valid, i);
      end
      @(posedge clk); #1;
    end
    check_count("reset_no_stale", n_out - n0, 0);

`ifdef PIPE_ADDER_SUB_EN
    add_pair(16'h8000, 16'h0001, 1'b0, 1'b1);
    stream(0, 0, 1'b0, 50);
    check_last("sub_8000_0001", 16'h7FFF, 1'b1);
    n_tests++;
    assert (last_ovf === 1'b1) else begin
      n_fail++;
      $error("FAIL sub_ovf: got %b want 1", last_ovf);
    end
`endif

    // randomized traffic with random bubbles and backpressure
    n0 = n_out;
    for (int i = 0; i < 40; i++) begin
`ifdef PIPE_ADDER_SUB_EN
      add_pair(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      add_pair(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
`endif
    end
    stream(0, 0, 1'b1, 3000);
    check_count("random_count", n_out - n0, 40);
    check_count("random_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
